// File: rtl/booth4_mult_seq_if.sv
// Handshake and operand/result bundle for the sequential radix-4 Booth multiplier.
interface booth4_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/booth4_mult_seq.sv
// Iterative radix-4 Booth multiplier: one recoded multiplier digit retired per clock.
module booth4_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  booth4_mult_seq_if.slave  bus
);

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int ACCW = 2 * WIDTH + 2;
  localparam int XW   = WIDTH + 2;
  localparam int CW   = (NDIG > 2) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [CW-1:0]        cnt_r;
  logic [ACCW-1:0]      acc_r;
  logic [ACCW-1:0]      mcand_r;
  logic [XW:0]          mplier_r;
  logic [2*WIDTH-1:0]   product_r;
  logic                 busy_r;
  logic                 done_r;
  logic [ACCW-1:0]      pp_s;
  logic                 cin_s;
  logic [ACCW-1:0]      acc_next_s;
  logic                 last_dig_s;

  // Booth recode of one triple into {partial product, carry-in}; negatives are invert + carry.
  function automatic logic [ACCW:0] booth_pp(input logic [2:0] trip, input logic [ACCW-1:0] m);
    logic [ACCW-1:0] m2;
    m2 = {m[ACCW-2:0], 1'b0};
    case (trip)
      3'b001, 3'b010: booth_pp = {m, 1'b0};
      3'b011:         booth_pp = {m2, 1'b0};
      3'b100:         booth_pp = {~m2, 1'b1};
      3'b101, 3'b110: booth_pp = {~m, 1'b1};
      default:        booth_pp = {(ACCW + 1){1'b0}};
    endcase
  endfunction

  function automatic logic [ACCW-1:0] ext_acc(input logic [WIDTH-1:0] v, input logic sm);
    ext_acc = {{(ACCW - WIDTH){sm & v[WIDTH-1]}}, v};
  endfunction

  // Adder for the current digit; the multiplicand is pre-shifted so no variable shifter is needed.
  always_comb begin
    {pp_s, cin_s} = booth_pp(mplier_r[2:0], mcand_r);
    acc_next_s    = acc_r + pp_s + {{(ACCW - 1){1'b0}}, cin_s};
    last_dig_s    = (cnt_r == CW'(NDIG - 1));
  end

  // Next-state logic of the control FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_dig_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and registered outputs; busy/done come from the next state so they align with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {ACCW{1'b0}};
      mcand_r   <= {ACCW{1'b0}};
      mplier_r  <= {(XW + 1){1'b0}};
      product_r <= {(2 * WIDTH){1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE);
      done_r <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            mcand_r  <= ext_acc(bus.a, bus.signed_mode);
            mplier_r <= {{2{bus.signed_mode & bus.b[WIDTH-1]}}, bus.b, 1'b0};
            acc_r    <= {ACCW{1'b0}};
            cnt_r    <= {CW{1'b0}};
          end
        end
        RUN: begin
          acc_r    <= acc_next_s;
          mcand_r  <= {mcand_r[ACCW-3:0], 2'b00};
          mplier_r <= {2'b00, mplier_r[XW:2]};
          cnt_r    <= cnt_r + CW'(1);
          if (last_dig_s) begin
            product_r <= acc_next_s[2*WIDTH-1:0];
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_booth4_mult_seq.sv
// Scoreboard bench: WIDTH=8 directed/back-to-back/reset tests plus an exhaustive WIDTH=4 sweep.
module tb_booth4_mult_seq;

  localparam int NDIG8 = 5;
  localparam int NDIG4 = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  int          cnt8 = 0;
  int          cnt4 = 0;
  logic [15:0] mprod8 = 16'h0000;
  logic [7:0]  mprod4 = 8'h00;
  logic [15:0] q8[$];
  logic [7:0]  q4[$];

  booth4_mult_seq_if #(.WIDTH(8)) bus8 ();
  booth4_mult_seq_if #(.WIDTH(4)) bus4 ();

  booth4_mult_seq #(.WIDTH(8)) dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8));
  booth4_mult_seq #(.WIDTH(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input int w, input logic sm,
                                          input logic [7:0] x, input logic [7:0] y);
    longint ex, ey, p;
    ex = longint'(x);
    ey = longint'(y);
    if (sm && x[w-1]) ex = ex - (longint'(1) << w);
    if (sm && y[w-1]) ey = ey - (longint'(1) << w);
    p = ex * ey;
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Acceptance model: push the expected product whenever an idle DUT sees start.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt8 <= 0;
      cnt4 <= 0;
      q8.delete();
      q4.delete();
    end else begin
      if (cnt8 == 0) begin
        if (bus8.start) begin
          cnt8 <= NDIG8 + 1;
          q8.push_back(ref_mul(8, bus8.signed_mode, bus8.a, bus8.b));
        end
      end else begin
        cnt8 <= cnt8 - 1;
      end
      if (cnt4 == 0) begin
        if (bus4.start) begin
          cnt4 <= NDIG4 + 1;
          q4.push_back(8'(ref_mul(4, bus4.signed_mode, {4'h0, bus4.a}, {4'h0, bus4.b})));
        end
      end else begin
        cnt4 <= cnt4 - 1;
      end
    end
  end

  // Output checker on the falling edge: busy, done timing, product on done and hold otherwise.
  always @(negedge clk) begin
    if (!reset_n) begin
      mprod8 <= 16'h0000;
      mprod4 <= 8'h00;
    end else begin
      check("busy8", bus8.busy, cnt8 != 0);
      check("done8", bus8.done, cnt8 == 1);
      if (cnt8 == 1) begin
        check("sb8_depth", q8.size(), 1);
        if (q8.size() > 0) begin
          check("prod8", bus8.product, q8[0]);
          mprod8 <= q8[0];
          void'(q8.pop_front());
        end
      end else begin
        check("hold8", bus8.product, mprod8);
      end
      check("busy4", bus4.busy, cnt4 != 0);
      check("done4", bus4.done, cnt4 == 1);
      if (cnt4 == 1) begin
        check("sb4_depth", q4.size(), 1);
        if (q4.size() > 0) begin
          check("prod4", bus4.product, q4[0]);
          mprod4 <= q4[0];
          void'(q4.pop_front());
        end
      end else begin
        check("hold4", bus4.product, mprod4);
      end
    end
  end

  task automatic op8(input logic sm, input logic [7:0] x, input logic [7:0] y,
                     input logic [15:0] lit, input string tag);
    @(negedge clk);
    bus8.start       = 1'b1;
    bus8.signed_mode = sm;
    bus8.a           = x;
    bus8.b           = y;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = ~x;
    bus8.b     = ~y;
    repeat (NDIG8 + 1) @(negedge clk);
    check(tag, bus8.product, lit);
  endtask

  initial begin
    bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
    bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0;
    #12;
    check("rst_busy8", bus8.busy, 1'b0);
    check("rst_done8", bus8.done, 1'b0);
    check("rst_prod8", bus8.product, 16'h0000);
    check("rst_busy4", bus4.busy, 1'b0);
    check("rst_prod4", bus4.product, 8'h00);
    #1 reset_n = 1'b1;

    fork
      begin
        op8(1'b1, 8'h07, 8'hFD, 16'hFFEB, "s_7xm3");
        op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ffxff");
        op8(1'b1, 8'hFF, 8'hFF, 16'h0001, "s_ffxff");
        op8(1'b1, 8'h80, 8'h80, 16'h4000, "s_80x80");
        op8(1'b1, 8'h80, 8'h7F, 16'hC080, "s_80x7f");
        op8(1'b0, 8'h00, 8'hAB, 16'h0000, "u_zero");
        // Start held high with operands scrambled every cycle.
        for (int i = 0; i < 4 * (NDIG8 + 2); i++) begin
          @(negedge clk);
          bus8.start       = 1'b1;
          bus8.signed_mode = 1'($urandom_range(0, 1));
          bus8.a           = 8'($urandom);
          bus8.b           = 8'($urandom);
        end
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (NDIG8 + 2) @(negedge clk);
      end
      begin
        for (int sm = 0; sm < 2; sm++) begin
          for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
              @(negedge clk);
              bus4.start       = 1'b1;
              bus4.signed_mode = 1'(sm);
              bus4.a           = 4'(x);
              bus4.b           = 4'(y);
              @(negedge clk);
              bus4.start = 1'b0;
              repeat (NDIG4) @(negedge clk);
            end
          end
        end
        repeat (2) @(negedge clk);
      end
    join

    // Abort mid-run once the digit counter has reached 2.
    @(negedge clk);
    bus8.start = 1'b1; bus8.signed_mode = 1'b1; bus8.a = 8'h35; bus8.b = 8'hC9;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy8", bus8.busy, 1'b0);
    check("abort_done8", bus8.done, 1'b0);
    check("abort_prod8", bus8.product, 16'h0000);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    op8(1'b1, 8'h35, 8'hC9, 16'hF49D, "post_rst_s");
    op8(1'b0, 8'h35, 8'hC9, 16'h299D, "post_rst_u");

    repeat (2) @(negedge clk);
    check("sb8_drain", q8.size(), 0);
    check("sb4_drain", q4.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
